mem_handshake_ram: RTL

Byte-addressable, big-endian data/instruction memory that sits directly downstream of the CPU datapath's MAR and DataIn registers and upstream of its IR and data-in muxes. It accepts requests over the MOV/MOC handshake and supports byte, halfword and word transfers with optional sign extension on loads. It inserts a programmable number of wait cycles before signalling completion, so the control unit's memory-wait states are exercised.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_byte_array.sv | 27 ++
 rtl/mem_handshake_ram.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the handshake RAM: size encodings, FSM states, counter width.
package mem_pkg;

    // Wide enough for the full 0..15 wait-cycle range.
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

    // Byte-lane enables for a big-endian word: lane 3 (bits 31:24) is byte offset 0.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offs);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b1000 >> offs;
            SIZE_HALF: mask = offs[1] ? 4'b0011 : 4'b1100;
            default:   mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte storage with four big-endian lane write enables and a combinational word read.
module mem_byte_array #(
    parameter int unsigned AddrBits = 9
) (
    input  logic                clk_i,
    input  logic [AddrBits-3:0] word_addr_i,
    input  logic                we_i,
    input  logic [3:0]          be_i,
    input  logic [31:0]         wdata_i,
    output logic [31:0]         rdata_o
);

    logic [7:0] mem [2**AddrBits];

    // Commit enabled lanes; no reset so contents survive a control reset.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < 4; l++) begin
            if (we_i && be_i[l]) begin
                mem[{word_addr_i, 2'(3 - l)}] <= wdata_i[8*l +: 8];
            end
        end
    end

    assign rdata_o = {mem[{word_addr_i, 2'd0}], mem[{word_addr_i, 2'd1}],
                      mem[{word_addr_i, 2'd2}], mem[{word_addr_i, 2'd3}]};

endmodule

// File: rtl/mem_handshake_ram.sv
// MOV/MOC handshake RAM with programmable wait cycles, big-endian byte/half/word access.
// Define MEM_ALIGN_TRAP_EN to add the Fault output and trap misaligned accesses;
// otherwise misaligned addresses are silently force-aligned.
module mem_handshake_ram
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 9,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MOV,
    input  logic        RW,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    input  logic [1:0]  Size,
    input  logic        SE,
    output logic [31:0] DataOut,
    output logic        MOC
`ifdef MEM_ALIGN_TRAP_EN
    ,
    output logic        Fault
`endif
);

    localparam logic [CNT_W-1:0] WaitInit = CNT_W'(WAIT_CYCLES);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 rw_q, rw_d;
    logic                 se_q, se_d;
    logic [1:0]           size_q, size_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          dout_q, dout_d;
    logic                 moc_q, moc_d;

    logic [31:0] rdata;
    logic [31:0] rd_ext;
    logic [31:0] wr_lanes;
    logic [3:0]  be;
    logic        mem_we;
    logic        complete;
    logic        trap;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Address bits above the decoded range are ignored so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^Address[31:ADDR_BITS];

    assign complete = (state_q == StBusy) && MOV && (cnt_q == '0);

`ifdef MEM_ALIGN_TRAP_EN
    logic misaligned;
    logic fault_q;

    // Halfwords need A[0] clear, words need A[1:0] clear.
    always_comb begin
        misaligned = 1'b0;
        case (size_q)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addr_q[0];
            default:   misaligned = |addr_q[1:0];
        endcase
    end

    // Fault shadows MOC: set with it on a misaligned completion, cleared when it falls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (complete) begin
            fault_q <= misaligned;
        end else if (state_q == StDone && !MOV) begin
            fault_q <= 1'b0;
        end
    end

    assign trap  = misaligned;
    assign Fault = fault_q;
`else
    assign trap = 1'b0;
`endif

    // Steer right-justified write data onto every lane it could occupy; be selects the live ones.
    always_comb begin
        be = lane_mask(size_q, addr_q[1:0]);
        case (size_q)
            SIZE_BYTE: wr_lanes = {4{wdata_q[7:0]}};
            SIZE_HALF: wr_lanes = {2{wdata_q[15:0]}};
            default:   wr_lanes = wdata_q;
        endcase
    end

    // Pick the addressed byte/halfword out of the aligned word and extend it.
    always_comb begin
        rd_byte = rdata[31:24];
        case (addr_q[1:0])
            2'd0:    rd_byte = rdata[31:24];
            2'd1:    rd_byte = rdata[23:16];
            2'd2:    rd_byte = rdata[15:8];
            default: rd_byte = rdata[7:0];
        endcase
        rd_half = addr_q[1] ? rdata[15:0] : rdata[31:16];
        case (size_q)
            SIZE_BYTE: rd_ext = se_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            SIZE_HALF: rd_ext = se_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            default:   rd_ext = rdata;
        endcase
    end

    // Handshake FSM: accept, count down wait cycles, perform access, hold MOC until MOV drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        se_d    = se_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        moc_d   = moc_q;
        mem_we  = 1'b0;
        case (state_q)
            StIdle: begin
                if (MOV) begin
                    addr_d  = Address[ADDR_BITS-1:0];
                    rw_d    = RW;
                    se_d    = SE;
                    size_d  = Size;
                    wdata_d = DataIn;
                    cnt_d   = WaitInit;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!MOV) begin
                    // Abort: nothing committed, outputs untouched.
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StDone;
                    moc_d   = 1'b1;
                    if (trap) begin
                        dout_d = '0;
                    end else if (rw_q) begin
                        dout_d = rd_ext;
                    end else begin
                        mem_we = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                if (!MOV) begin
                    state_d = StIdle;
                    moc_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and request registers; reset clears control only, storage is untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            se_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            wdata_q <= '0;
            dout_q  <= '0;
            moc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            se_q    <= se_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
        end
    end

    mem_byte_array #(
        .AddrBits (ADDR_BITS)
    ) u_mem (
        .clk_i       (clk),
        .word_addr_i (addr_q[ADDR_BITS-1:2]),
        .we_i        (mem_we),
        .be_i        (be),
        .wdata_i     (wr_lanes),
        .rdata_o     (rdata)
    );

    assign DataOut = dout_q;
    assign MOC     = moc_q;

endmodule
